// File: rtl/mutative_dfp_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : mutative_types
// Shared types and constants for the mutative cache memory-port arbiter.
// Rev     : 1.0
// ---------------------------------------------------------------------------
package mutative_types;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  localparam int LINE_OFFSET_BITS = line_offset_bits(256);

endpackage
`default_nettype wire

// File: rtl/mutative_dfp_arbiter_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rr_picker
// Combinational round-robin encoder; search begins one past the last winner.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  int w_cand;

  // Walk farthest-to-nearest so the closest requester after last overwrites.
  always_comb begin
    valid  = |req;
    idx    = '0;
    w_cand = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand = int'(last) + k;
      if (w_cand >= NUM_PORTS) w_cand = w_cand - NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j == w_cand && req[j]) idx = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mutative_dfp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mutative_dfp_arbiter
// Round-robin share of one line-wide memory port among NUM_PORTS caches.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module mutative_dfp_arbiter
  import mutative_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS*LINE_WIDTH-1:0] req_rdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [LINE_WIDTH-1:0]           mem_wdata,
  input  logic [LINE_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_resp,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  wait_cnt
);

  localparam int C_IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int C_OFF_BITS = line_offset_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_MASK = {ADDR_WIDTH{1'b1}} << C_OFF_BITS;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic                   w_launch;
  logic                   w_done;
  logic [NUM_PORTS-1:0]   w_req;
  logic                   w_pick_valid;
  logic [C_IDX_W-1:0]     w_pick_idx;
  logic [C_IDX_W-1:0]     r_grant_idx;
  logic [C_IDX_W-1:0]     r_last_grant;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [LINE_WIDTH-1:0]  w_sel_wdata;
  logic                   w_sel_wr;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [LINE_WIDTH-1:0]  r_mem_wdata;
  logic                   r_mem_read;
  logic                   r_mem_write;

  assign w_req = req_read | req_write;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (C_IDX_W)
  ) u_rr_picker (
    .req   (w_req),
    .last  (r_last_grant),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // A port asserting both read and write is treated as a write.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_pick_idx == C_IDX_W'(j)) begin
        w_sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[j*LINE_WIDTH +: LINE_WIDTH];
        w_sel_wr    = req_write[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_pick_valid) begin
        w_launch    = 1'b1;
        w_state_nxt = ARB_BUSY;
      end
      ARB_BUSY: if (mem_resp) begin
        w_done      = 1'b1;
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_grant_idx  <= '0;
      r_last_grant <= C_IDX_W'(NUM_PORTS - 1);
    end else if (w_launch) begin
      r_mem_addr   <= w_sel_addr & C_ADDR_MASK;
      r_mem_wdata  <= w_sel_wdata;
      r_mem_read   <= ~w_sel_wr;
      r_mem_write  <= w_sel_wr;
      r_grant_idx  <= w_pick_idx;
      r_last_grant <= w_pick_idx;
    end else if (w_done) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign req_rdata = {NUM_PORTS{mem_rdata}};

  always_comb begin
    req_resp = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      req_resp[j] = w_done && (r_grant_idx == C_IDX_W'(j));
    end
  end

  // The winning cycle and the port's own busy window are not counted as waiting.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wait
    logic                 w_inc;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_inc = w_req[gi]
                && !((r_state == ARB_BUSY) && (r_grant_idx == C_IDX_W'(gi)))
                && !(w_launch && (w_pick_idx == C_IDX_W'(gi)));

    always_ff @(posedge clk) begin
      if (rst)                           r_cnt <= '0;
      else if (w_inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
    end

    assign wait_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

  a_no_rw_conflict: assert property (@(posedge clk) disable iff (rst) !(|(req_read & req_write)));

endmodule
`default_nettype wire

// File: tb/tb_mutative_dfp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_mutative_dfp_arbiter
// Scoreboard bench: expected grants queued at stimulus, popped on grant.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_mutative_dfp_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*LW-1:0] req_wdata;
  logic [N*LW-1:0] req_rdata;
  logic [N-1:0]    req_resp;
  logic [AW-1:0]   mem_addr;
  logic            mem_read;
  logic            mem_write;
  logic [LW-1:0]   mem_wdata;
  logic [LW-1:0]   mem_rdata;
  logic            mem_resp;
  logic [N*CW-1:0] wait_cnt;

  always #5 clk = ~clk;

  mutative_dfp_arbiter #(
    .NUM_PORTS  (N),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_resp  (req_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .wait_cnt  (wait_cnt)
  );

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            mem_lat = 4;
  int            gap_exp = -1;
  int            last_resp_cyc = 0;
  logic [LW-1:0] rd_pat = '0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic wr, input logic [LW-1:0] d);
    exp_t e;
    e.port  = p;
    e.addr  = a & ~32'h1F;
    e.wr    = wr;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Called at a drive point; returns at the drive point after the response.
  task automatic do_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    bit got = 1'b0;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*LW +: LW] = d;
    if (wr) req_write[p] = 1'b1;
    else    req_read[p]  = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      #1;
      if (req_resp[p]) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) check_eq($sformatf("req_timeout_port%0d", p), 0, 1);
    @(posedge clk);
    #1;
    req_read[p]  = 1'b0;
    req_write[p] = 1'b0;
  endtask

  // Memory model: respond mem_lat cycles after the request first appears.
  initial begin
    int cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
      end else if ((mem_read || mem_write) && !rst) begin
        if (cnt == mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = rd_pat;
          cnt       = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Grant/response monitor against the expectation queue.
  initial begin
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   prev_act = 1'b0;
    bit   act;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (rst) begin
        have_cur = 1'b0;
        prev_act = 1'b0;
      end else begin
        act = mem_read | mem_write;
        if (act && !prev_act) begin
          if (exp_q.size() == 0) check_eq("unexpected_grant", 1, 0);
          else begin
            cur = exp_q.pop_front();
            check_eq($sformatf("grant_p%0d_addr", cur.port), mem_addr, cur.addr);
            check_eq("grant_write", mem_write, cur.wr);
            check_eq("grant_read", mem_read, !cur.wr);
            if (cur.wr) check_eq("grant_wdata", mem_wdata, cur.wdata);
            if (gap_exp > 0) check_eq("idle_gap", cyc - last_resp_cyc, gap_exp);
            have_cur = 1'b1;
          end
        end
        if (mem_resp || req_resp != '0) begin
          if (!have_cur) check_eq("unexpected_resp", req_resp, 0);
          else begin
            check_eq($sformatf("resp_onehot_p%0d", cur.port), req_resp, 1 << cur.port);
            if (!cur.wr) check_eq("resp_rdata", req_rdata[cur.port*LW +: LW], rd_pat);
            have_cur      = 1'b0;
            last_resp_cyc = cyc;
          end
        end
        prev_act = act;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_read  = '0;
    req_wdata = '0;
    req_write = '0;
    do_reset();
    #1;
    check_eq("reset_mem_read", mem_read, 0);
    check_eq("reset_mem_write", mem_write, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_mem_wdata", mem_wdata, 0);
    check_eq("reset_req_resp", req_resp, 0);
    check_eq("reset_wait_cnt", wait_cnt, 0);
    #1;

    // Single read with a 10-cycle memory
    mem_lat = 10;
    rd_pat  = {32{8'hAA}};
    expect_txn(0, 32'h0000_1234, 1'b0, '0);
    fork
      do_req(0, 1'b0, 32'h0000_1234, '0);
      begin
        #1;
        check_eq("grant_not_same_cycle", mem_read, 0);
        @(posedge clk);
        #2;
        check_eq("grant_latency_read", mem_read, 1);
        check_eq("grant_latency_addr", mem_addr, 32'h0000_1220);
      end
    join

    // Simultaneous requests after reset
    do_reset();
    mem_lat = 4;
    rd_pat  = {16{16'hC3A5}};
    expect_txn(0, 32'h0000_0040, 1'b0, '0);
    expect_txn(1, 32'h0000_0080, 1'b0, '0);
    fork
      do_req(0, 1'b0, 32'h0000_0040, '0);
      do_req(1, 1'b0, 32'h0000_0080, '0);
    join
    check_eq("simul_wait0", wait_cnt[0*CW +: CW], 0);
    check_eq("simul_wait1", wait_cnt[1*CW +: CW], 6);

    // Round-robin under saturation
    do_reset();
    mem_lat = 2;
    for (int k = 0; k < 4; k++) begin
      expect_txn(0, 32'h0001_0000 + k * 32'h100, 1'b0, '0);
      expect_txn(1, 32'h0002_0000 + k * 32'h100, 1'b0, '0);
    end
    fork
      for (int k = 0; k < 4; k++) do_req(0, 1'b0, 32'h0001_0000 + k * 32'h100, '0);
      for (int k = 0; k < 4; k++) do_req(1, 1'b0, 32'h0002_0000 + k * 32'h100, '0);
    join

    // Dirty evict then refill on the same port
    do_reset();
    mem_lat = 3;
    rd_pat  = {32{8'h3C}};
    expect_txn(1, 32'h0000_4000, 1'b1, {32{8'h55}});
    do_req(1, 1'b1, 32'h0000_4000, {32{8'h55}});
    gap_exp = 2;
    expect_txn(1, 32'h0000_8000, 1'b0, '0);
    do_req(1, 1'b0, 32'h0000_8000, '0);
    gap_exp = -1;

    // Reset in the middle of a transaction
    do_reset();
    mem_lat = 30;
    expect_txn(0, 32'h0000_7000, 1'b0, '0);
    req_addr[0 +: AW] = 32'h0000_7000;
    req_read[0]       = 1'b1;
    tick();
    tick();
    tick();
    check_eq("midrst_busy", mem_read, 1);
    rst         = 1'b1;
    req_read[0] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_mem_read", mem_read, 0);
    check_eq("midrst_mem_write", mem_write, 0);
    check_eq("midrst_req_resp", req_resp, 0);
    check_eq("midrst_wait_cnt", wait_cnt, 0);
    #1;
    mem_lat = 2;
    expect_txn(0, 32'h0000_9000, 1'b0, '0);
    expect_txn(1, 32'h0000_A000, 1'b0, '0);
    fork
      do_req(0, 1'b0, 32'h0000_9000, '0);
      do_req(1, 1'b0, 32'h0000_A000, '0);
    join

    // Wait counter saturation
    do_reset();
    mem_lat = 20;
    expect_txn(0, 32'h0000_B000, 1'b0, '0);
    expect_txn(1, 32'h0000_C000, 1'b0, '0);
    fork
      do_req(0, 1'b0, 32'h0000_B000, '0);
      do_req(1, 1'b0, 32'h0000_C000, '0);
    join
    check_eq("sat_wait0", wait_cnt[0*CW +: CW], 0);
    check_eq("sat_wait1", wait_cnt[1*CW +: CW], 15);

    tick();
    tick();
    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mutative_dfp_arbiter.md
# mutative_dfp_arbiter

Shares one downward-facing memory port between `NUM_PORTS` mutative caches (default: instruction cache and data cache). Each cache presents its `dfp_*` interface upward into this block. The block grants one line transaction at a time to the memory controller, using round-robin priority. It latches the granted request, routes the response back to the winner, and keeps per-port wait-cycle counters for performance analysis.

## Interface
- `NUM_PORTS`, 2: number of requesting caches (2–8).
- `ADDR_WIDTH`, 32: byte address width.
- `LINE_WIDTH`, 256: cacheline width in bits.
- `CNT_WIDTH`, 32: width of each wait counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_addr`  in  `NUM_PORTS*ADDR_WIDTH`  per-port line address; port i occupies slice i.
- `req_read`  in  `NUM_PORTS`  per-port line read request, level, held until `req_resp`.
- `req_write`  in  `NUM_PORTS`  per-port line write request, level, held until `req_resp`.
- `req_wdata`  in  `NUM_PORTS*LINE_WIDTH`  per-port write line.
- `req_rdata`  out  `NUM_PORTS*LINE_WIDTH`  read line; all slices carry `mem_rdata`.
- `req_resp`  out  `NUM_PORTS`  one-cycle completion pulse, one-hot.
- `mem_addr`  out  `ADDR_WIDTH`  memory line address.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `mem_wdata`  out  `LINE_WIDTH`  memory write line.
- `mem_rdata`  in  `LINE_WIDTH`  memory read line, valid with `mem_resp`.
- `mem_resp`  in  1  memory completion.
- `wait_cnt`  out  `NUM_PORTS*CNT_WIDTH`  per-port count of cycles spent requesting but not granted.

## Operation
- **States:** `ARB_IDLE`, `ARB_BUSY`.
- **`ARB_IDLE`, no request pending:** outputs idle; stay in `ARB_IDLE`.
- **`ARB_IDLE`, at least one port with `req_read|req_write`:**
  - Pick a winner by round-robin. Search starts at `last_grant+1` and wraps modulo `NUM_PORTS`.
  - Latch the winner's address with the low `$clog2(LINE_WIDTH/8)` bits forced to 0, its wdata, and its op into `mem_*` registers.
  - Set `grant_idx` and `last_grant` to the winner.
  - Go to `ARB_BUSY`.
- **Read and write asserted together by one port:** illegal. The write wins and an assertion fires in simulation.
- **`ARB_BUSY`:** hold `mem_read`/`mem_write` from the registers.
  - On `mem_resp`, assert `req_resp[grant_idx]` that same cycle.
  - Drop `mem_read`/`mem_write` next cycle and return to `ARB_IDLE`.
- **Re-arbitration:** requests seen during the `mem_resp` cycle are ignored. Arbitration resumes in the following `ARB_IDLE` cycle, by which time the winner has deasserted its request.
- **Request changes during `ARB_BUSY`:** changes on the granted port's inputs are ignored, because the request is latched. Non-granted ports keep waiting.
- **`wait_cnt[i]`:**
  - Increments every cycle that port i requests and (state ≠ `ARB_BUSY` or `grant_idx` ≠ i), excluding the single `ARB_IDLE` cycle in which port i wins.
  - Saturates at all-ones.
- **Reset values:**
  - `mem_read`, `mem_write`, `req_resp`: 0.
  - `mem_addr`, `mem_wdata`: 0.
  - `wait_cnt`: 0.
  - State: `ARB_IDLE`.
  - `last_grant`: `NUM_PORTS-1`, so port 0 wins first.
- **Reset mid-transaction:** abandon the transaction. The next cycle shows no request, and no `req_resp` is produced.

## Timing
- **Grant latency:** request sampled in `ARB_IDLE` at cycle 0; `mem_read`/`mem_write` high from cycle 1.
- **Response latency:** `req_resp` is combinational from `mem_resp` (`ARB_BUSY` & `mem_resp`), so no added response latency.
- **Read data:** `req_rdata` is a combinational fan-out of `mem_rdata`.
- **Back-to-back:** minimum gap between two memory transactions is 1 idle cycle (resp cycle N, next request cycle N+2).
- **Fairness:** with all ports continuously requesting, each port waits at most `NUM_PORTS-1` transactions.

## Structure
- **Shared package (`mutative_types`):**
  - `arb_state_t` enum { `ARB_IDLE`, `ARB_BUSY` }.
  - Constant `LINE_OFFSET_BITS` = `$clog2(LINE_WIDTH/8)`.
- **Sub-module `rr_picker`:**
  - Combinational round-robin priority encoder.
  - Inputs: `req` vector, `last` index.
  - Outputs: `valid`, winner index.
  - Reusable by future multi-bank schedulers.

## Test plan
- **Single read:** port 0 `req_read`, addr `0x0000_1234`. `mem_read` goes high the next cycle with `mem_addr` = `0x0000_1220`. Memory responds 10 cycles later with `0xAA…`. `req_resp` = `01` in that cycle and `req_rdata[0]` = `0xAA…`.
- **Simultaneous requests after reset:** both ports request reads at cycle 0. Port 0 is served first, then port 1. `wait_cnt[1]` equals port 0's busy length + 2; `wait_cnt[0]` = 0.
- **Round-robin under saturation:** both ports re-request immediately after every resp for 8 transactions. Grants alternate 0,1,0,1,…. No port is granted twice consecutively while the other is requesting.
- **Write then read, same port (dirty evict):** port 1 writes `0x0000_4000` with data `0x55…`. `mem_write`/`mem_wdata` are correct. After resp, port 1 reads `0x0000_8000`, served after 1 idle cycle.
- **Reset mid-transaction:** assert `rst` during `ARB_BUSY`. The next cycle `mem_read` = `mem_write` = 0, `req_resp` = 0, and counters are 0. The first post-reset request grants port 0.
- **Counter saturation:** with `CNT_WIDTH` = 4, hold port 1 requesting while port 0 occupies memory for 20 cycles. `wait_cnt[1]` stops at 15.
